// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller slice: FSM state
// encodings, snake length width and the BCD digit helper.
package snake_pkg;

  localparam logic [1:0] ST_PREPARE = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_END     = 2'd2;

  localparam int SIZE_W = 5;
  localparam int BCD_W  = 4;

  // Increment one BCD digit; returns {carry, next_digit}. 9 wraps to 0 with carry.
  function automatic logic [BCD_W:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
    if (d == BCD_W'(9)) begin
      return {1'b1, {BCD_W{1'b0}}};
    end
    return {1'b0, d + BCD_W'(1)};
  endfunction

endpackage

// File: rtl/snake_bcd_counter.sv
// Two-digit BCD event counter for the score display. Synchronous clear has
// priority over increment; 99 wraps to 00. Async active-low reset.
module snake_bcd_counter
  import snake_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [2*BCD_W-1:0] o_bcd
);

  logic [BCD_W-1:0] r_lo;
  logic [BCD_W-1:0] r_hi;
  logic [BCD_W:0]   w_lo_inc;
  logic [BCD_W:0]   w_hi_inc;

  // Next value of each digit if incremented, with its carry out.
  always_comb begin
    w_lo_inc = bcd_digit_inc(r_lo);
    w_hi_inc = bcd_digit_inc(r_hi);
  end

  // Digit registers; tens digit only advances on a units carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (i_clr) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (i_inc) begin
      r_lo <= w_lo_inc[BCD_W-1:0];
      if (w_lo_inc[BCD_W]) begin
        r_hi <= w_hi_inc[BCD_W-1:0];
      end
    end
  end

  assign o_bcd = {r_hi, r_lo};

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-level controller upstream of the snake datapath: PREPARE/RUN/END FSM,
// eat-event qualification with a hold-off window, size growth and BCD score.
// Optional build macro AUTO_RESTART_EN: END returns to PREPARE on its own once
// the end counter reaches END_HOLD instead of waiting for a restart edge.
// dbg_state exposes the raw FSM state for observation.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int INIT_SIZE   = 3,
  parameter int MAX_SIZE    = 31,
  parameter int EAT_HOLDOFF = 1666667,
  parameter int END_HOLD    = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              userStart,
  input  logic              snakeEatCherry,
  input  logic              bump,
  input  logic              restart,
  output logic              gamePrepare,
  output logic              gameStart,
  output logic              gameEnd,
  output logic [SIZE_W-1:0] size,
  output logic [7:0]        score,
  output logic              win,
  output logic [1:0]        dbg_state
);

  localparam int HO_W = $clog2(EAT_HOLDOFF + 1);
  localparam int EC_W = $clog2(END_HOLD + 1);
  localparam logic [HO_W-1:0]   HO_RELOAD = HO_W'(EAT_HOLDOFF - 1);
  localparam logic [EC_W-1:0]   EC_MAX    = EC_W'(END_HOLD);
  localparam logic [SIZE_W-1:0] SZ_INIT   = SIZE_W'(INIT_SIZE);
  localparam logic [SIZE_W-1:0] SZ_MAX    = SIZE_W'(MAX_SIZE);

  logic [1:0]        r_state;
  logic              r_prep, r_run, r_end;
  logic              r_start_d, r_eat_d, r_restart_d;
  logic [HO_W-1:0]   r_holdoff;
  logic [EC_W-1:0]   r_end_cnt;
  logic [SIZE_W-1:0] r_size;
  logic              r_win;

  logic              w_start_ev, w_eat_ev, w_restart_ev;
  logic              w_eat_ok, w_hit_max, w_end_done, w_leave_end, w_bcd_clr;
  logic [SIZE_W:0]   w_size_inc;
  logic [1:0]        w_state_nxt;

  // Rising-edge events and eat qualification (bump wins over a same-cycle eat).
  always_comb begin
    w_start_ev   = userStart & ~r_start_d;
    w_eat_ev     = snakeEatCherry & ~r_eat_d;
    w_restart_ev = restart & ~r_restart_d;
    w_size_inc   = {1'b0, r_size} + (SIZE_W+1)'(1);
    w_hit_max    = (w_size_inc == (SIZE_W+1)'(MAX_SIZE));
    w_eat_ok     = (r_state == ST_RUN) && !bump && w_eat_ev && (r_holdoff == '0);
    w_end_done   = (r_end_cnt == EC_MAX);
    w_bcd_clr    = (r_state == ST_PREPARE) && w_start_ev;
`ifdef AUTO_RESTART_EN
    w_leave_end  = w_end_done;
`else
    w_leave_end  = w_end_done && w_restart_ev;
`endif
  end

  // Next-state decode for the game phase FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PREPARE: if (w_start_ev) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bump) w_state_nxt = ST_END;
        else if (w_eat_ok && w_hit_max) w_state_nxt = ST_END;
      end
      ST_END: if (w_leave_end) w_state_nxt = ST_PREPARE;
      default: w_state_nxt = ST_PREPARE;
    endcase
  end

  // State, registered phase strobes, edge history, counters, size and win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_PREPARE;
      r_prep      <= 1'b1;
      r_run       <= 1'b0;
      r_end       <= 1'b0;
      r_start_d   <= 1'b0;
      r_eat_d     <= 1'b0;
      r_restart_d <= 1'b0;
      r_holdoff   <= '0;
      r_end_cnt   <= '0;
      r_size      <= SZ_INIT;
      r_win       <= 1'b0;
    end else begin
      r_start_d   <= userStart;
      r_eat_d     <= snakeEatCherry;
      r_restart_d <= restart;
      r_state     <= w_state_nxt;
      r_prep      <= (w_state_nxt == ST_PREPARE);
      r_run       <= (w_state_nxt == ST_RUN);
      r_end       <= (w_state_nxt == ST_END);
      if (r_state != ST_END) r_end_cnt <= '0;
      case (r_state)
        ST_PREPARE: begin
          if (w_start_ev) begin
            r_size    <= SZ_INIT;
            r_win     <= 1'b0;
            r_holdoff <= '0;
          end
        end
        ST_RUN: begin
          if (bump) begin
            r_win <= 1'b0;
          end else if (w_eat_ok) begin
            r_size    <= (r_size == SZ_MAX) ? r_size : w_size_inc[SIZE_W-1:0];
            r_holdoff <= HO_RELOAD;
            if (w_hit_max) r_win <= 1'b1;
          end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - HO_W'(1);
          end
        end
        ST_END: begin
          if (!w_end_done) r_end_cnt <= r_end_cnt + EC_W'(1);
        end
        default: ;
      endcase
    end
  end

  snake_bcd_counter u_score (
    .clk   (clk),
    .rst_n (rst),
    .i_inc (w_eat_ok),
    .i_clr (w_bcd_clr),
    .o_bcd (score)
  );

  assign gamePrepare = r_prep;
  assign gameStart   = r_run;
  assign gameEnd     = r_end;
  assign size        = r_size;
  assign win         = r_win;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with a small expected-state model and a
// scoreboard queue; also drives a standalone score counter through 99->00.
module tb_snake_game_ctrl;
  import snake_pkg::*;

  localparam int INIT_SIZE   = 3;
  localparam int MAX_SIZE    = 31;
  localparam int EAT_HOLDOFF = 4;
  localparam int END_HOLD    = 8;
  localparam int OBS_W       = 17;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       userStart = 1'b0, snakeEatCherry = 1'b0, bump = 1'b0, restart = 1'b0;
  logic       gamePrepare, gameStart, gameEnd, win;
  logic [4:0] size;
  logic [7:0] score;
  logic [1:0] dbg_state;

  logic       bcd_inc = 1'b0, bcd_clr = 1'b0;
  logic [7:0] bcd_out;

  int checks = 0;
  int failures = 0;

  logic [OBS_W-1:0] exp_q[$];
  string            tag_q[$];
  logic [7:0]       bcd_q[$];

  logic       m_prep, m_run, m_end, m_win;
  logic [4:0] m_size;
  logic [7:0] m_score, m_bcd;

  logic [OBS_W-1:0] obs_vec;
  assign obs_vec = {gamePrepare, gameStart, gameEnd, size, score, win};

  // clock
  always #5 clk = ~clk;

  snake_game_ctrl #(
    .INIT_SIZE(INIT_SIZE), .MAX_SIZE(MAX_SIZE),
    .EAT_HOLDOFF(EAT_HOLDOFF), .END_HOLD(END_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .userStart(userStart), .snakeEatCherry(snakeEatCherry),
    .bump(bump), .restart(restart), .gamePrepare(gamePrepare), .gameStart(gameStart),
    .gameEnd(gameEnd), .size(size), .score(score), .win(win), .dbg_state(dbg_state)
  );

  snake_bcd_counter u_bcd (
    .clk(clk), .rst_n(rst), .i_inc(bcd_inc), .i_clr(bcd_clr), .o_bcd(bcd_out)
  );

  function automatic logic [7:0] bcd_plus1(input logic [7:0] b);
    int v;
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    v = (v + 1) % 100;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic set_phase(input logic [1:0] p);
    m_prep = (p == ST_PREPARE);
    m_run  = (p == ST_RUN);
    m_end  = (p == ST_END);
  endtask

  task automatic model_reset();
    set_phase(ST_PREPARE);
    m_size  = 5'(INIT_SIZE);
    m_score = 8'h00;
    m_win   = 1'b0;
    m_bcd   = 8'h00;
  endtask

  task automatic push_exp(input string tag);
    exp_q.push_back({m_prep, m_run, m_end, m_size, m_score, m_win});
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    logic [OBS_W-1:0] e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs_vec === e) else begin
        failures++;
        $error("FAIL %s: observed %h expected %h (prep,run,end,size,score,win)", t, obs_vec, e);
      end
    end
  endtask

  task automatic tick(input string tag);
    push_exp(tag);
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic bcd_tick(input string tag);
    logic [7:0] e;
    bcd_q.push_back(m_bcd);
    @(posedge clk);
    @(negedge clk);
    e = bcd_q.pop_front();
    checks++;
    assert (bcd_out === e) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, bcd_out, e);
    end
  endtask

  // One accepted eat followed by enough idle cycles for the hold-off to expire.
  task automatic eat_once(input string tag);
    snakeEatCherry = 1'b1;
    m_size  = m_size + 5'd1;
    m_score = bcd_plus1(m_score);
    tick(tag);
    snakeEatCherry = 1'b0;
    repeat (EAT_HOLDOFF) tick({tag, "_gap"});
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #10;
    push_exp("reset_async");
    drain();
    @(negedge clk);
    rst = 1'b1;
    tick("reset_release");

    // PREPARE -> RUN
    userStart = 1'b1;
    set_phase(ST_RUN);
    tick("start");
    tick("start_held");
    userStart = 1'b0;
    tick("run_idle");

    // Eat held high: only one accepted
    snakeEatCherry = 1'b1;
    m_size = 5'd4; m_score = 8'h01;
    tick("eat_first");
    repeat (9) tick("eat_held");
    snakeEatCherry = 1'b0;
    tick("eat_release");

    // Hold-off boundary: edge while holdoff!=0 ignored, edge at holdoff==0 accepted
    snakeEatCherry = 1'b1;
    m_size = 5'd5; m_score = 8'h02;
    tick("eat_second");
    snakeEatCherry = 1'b0;
    tick("holdoff_run");
    snakeEatCherry = 1'b1;
    tick("eat_in_holdoff");
    snakeEatCherry = 1'b0;
    tick("holdoff_last");
    snakeEatCherry = 1'b1;
    m_size = 5'd6; m_score = 8'h03;
    tick("eat_at_zero");
    snakeEatCherry = 1'b0;
    repeat (EAT_HOLDOFF) tick("gap");

    // restart and userStart edges in RUN have no effect
    restart = 1'b1;
    tick("restart_in_run");
    restart = 1'b0;
    userStart = 1'b1;
    tick("start_in_run");
    userStart = 1'b0;
    tick("run_idle2");

    // Grow until the score crosses 09 -> 10
    while (m_score != 8'h10) eat_once("eat_loop");

    // Bump with same-cycle eat edge: END, no growth, no win
    snakeEatCherry = 1'b1;
    bump = 1'b1;
    set_phase(ST_END);
    m_win = 1'b0;
    tick("bump_with_eat");
    snakeEatCherry = 1'b0;
    bump = 1'b0;
    tick("end_cnt1");
    tick("end_cnt2");
    tick("end_cnt3");
    restart = 1'b1;
    tick("restart_early");
    restart = 1'b0;
    repeat (4) tick("end_wait");
`ifndef AUTO_RESTART_EN
    restart = 1'b1;
`endif
    set_phase(ST_PREPARE);
    tick("leave_end");
    restart = 1'b0;
    tick("prepare_idle");

    // Game 2: grow to MAX_SIZE -> win
    userStart = 1'b1;
    set_phase(ST_RUN);
    m_size = 5'(INIT_SIZE); m_score = 8'h00; m_win = 1'b0;
    tick("start2");
    userStart = 1'b0;
    while (int'(m_size) < MAX_SIZE - 1) eat_once("eat_grow");
    snakeEatCherry = 1'b1;
    m_size = 5'(MAX_SIZE);
    m_score = bcd_plus1(m_score);
    set_phase(ST_END);
    m_win = 1'b1;
    tick("eat_win");
    snakeEatCherry = 1'b0;
    snakeEatCherry = 1'b1;
    tick("eat_in_end");
    snakeEatCherry = 1'b0;
    repeat (END_HOLD - 1) tick("end_hold_win");
`ifndef AUTO_RESTART_EN
    restart = 1'b1;
`endif
    set_phase(ST_PREPARE);
    tick("leave_end_win");
    restart = 1'b0;
    tick("prepare_win_kept");
    restart = 1'b1;
    tick("restart_in_prepare");
    restart = 1'b0;

    // Game 3: win cleared on RUN entry, then async reset mid-RUN
    userStart = 1'b1;
    set_phase(ST_RUN);
    m_size = 5'(INIT_SIZE); m_score = 8'h00; m_win = 1'b0;
    tick("start3_win_cleared");
    userStart = 1'b0;
    eat_once("eat3");
    snakeEatCherry = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    push_exp("reset_mid_run");
    drain();
    @(negedge clk);
    snakeEatCherry = 1'b0;
    rst = 1'b1;
    tick("after_mid_reset");

    // Standalone score counter: full lap through 09->10 and 99->00
    m_bcd = 8'h00;
    bcd_inc = 1'b1;
    for (int i = 0; i < 101; i++) begin
      m_bcd = bcd_plus1(m_bcd);
      bcd_tick("bcd_count");
    end
    bcd_inc = 1'b0;
    bcd_tick("bcd_hold");
    bcd_clr = 1'b1;
    m_bcd = 8'h00;
    bcd_tick("bcd_clear");
    bcd_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
